// File: rtl/ddr2_tg_pkg.sv
// Shared types and constants for the DDR2 traffic generator.
// Holds the FSM state encoding and the burst address step helper.
package ddr2_tg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_GAP,
        S_WR_REQ,
        S_WR_BUSY,
        S_RD_GAP,
        S_RD_REQ,
        S_RD_BUSY
    } tg_state_e;

    localparam int unsigned DEF_BURST_LEN = 32;

    // Each beat carries two 16-bit DQ columns, so a burst spans 2*len columns.
    function automatic int unsigned tg_addr_step(input int unsigned blen);
        return 2 * blen;
    endfunction

    localparam int unsigned ADDR_STEP = tg_addr_step(DEF_BURST_LEN);

endpackage

// File: rtl/ddr2_tg_if.sv
// User-side request/data handshake between traffic generator and AXI masters.
// master: the traffic generator side; slave: the wr/rd AXI master side.
interface ddr2_tg_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) ();

    logic                  wr_trig;
    logic [7:0]            wr_len;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_data_en;
    logic                  wr_ready;
    logic                  wr_done;

    logic                  rd_trig;
    logic [7:0]            rd_len;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_en;
    logic                  rd_ready;
    logic                  rd_done;

    modport master (
        output wr_trig, wr_len, wr_addr, wr_data,
        input  wr_data_en, wr_ready, wr_done,
        output rd_trig, rd_len, rd_addr,
        input  rd_data, rd_data_en, rd_ready, rd_done
    );

    modport slave (
        input  wr_trig, wr_len, wr_addr, wr_data,
        output wr_data_en, wr_ready, wr_done,
        input  rd_trig, rd_len, rd_addr,
        output rd_data, rd_data_en, rd_ready, rd_done
    );

endinterface

// File: rtl/ddr2_tg_checker.sv
// Readback checker: compares read beats against the incrementing pattern.
// Ports: clk, clr_i (sync clear), rd_data_i/rd_data_en_i/rd_done_i, row_end_i -> status outputs.
module ddr2_tg_checker
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 32
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_en_i,
    input  logic                  rd_done_i,
    input  logic                  row_end_i,
    output logic                  rd_error_o,
    output logic [15:0]           err_cnt_o,
    output logic [15:0]           pass_cnt_o
);

    logic [DATA_WIDTH-1:0] exp_q;
    logic [15:0]           beat_q;
    logic [15:0]           beats_d;
    logic                  rd_error_q;
    logic [15:0]           err_q;
    logic [15:0]           err_d;
    logic [15:0]           pass_q;
    logic                  mism;
    logic                  len_err;
    logic [16:0]           err_sum;

    assign mism    = rd_data_en_i && (rd_data_i != exp_q);
    // Beat total includes a beat arriving in the same cycle as rd_done.
    assign beats_d = beat_q + {15'd0, rd_data_en_i};
    assign len_err = rd_done_i && (beats_d != 16'(BURST_LEN));
    // A data mismatch and a short burst can coincide: add both, then saturate.
    assign err_sum = {1'b0, err_q} + {15'd0, mism} + {15'd0, len_err};
    assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge clk) begin
        if (clr_i) begin
            exp_q      <= DATA_WIDTH'(1);
            beat_q     <= '0;
            rd_error_q <= 1'b0;
            err_q      <= '0;
            pass_q     <= '0;
        end else begin
            if (row_end_i) begin
                exp_q <= DATA_WIDTH'(1);
            end else if (rd_data_en_i) begin
                exp_q <= exp_q + DATA_WIDTH'(1);
            end
            if (rd_done_i) begin
                beat_q <= '0;
            end else begin
                beat_q <= beats_d;
            end
            if (mism || len_err) begin
                rd_error_q <= 1'b1;
            end
            err_q <= err_d;
            if (row_end_i) begin
                pass_q <= pass_q + 16'd1;
            end
        end
    end

    assign rd_error_o = rd_error_q;
    assign err_cnt_o  = err_q;
    assign pass_cnt_o = pass_q;

endmodule

// File: rtl/ddr2_traffic_gen.sv
// DDR2 traffic generator: writes one row with an incrementing pattern, then reads it back forever.
// Ports: clk, rst, init_end, bus (ddr2_tg_if.master), wr_over/rd_error/err_cnt/pass_cnt status.
// Build option: define DDR2_TG_CHECK_EN to include the readback checker.
module ddr2_traffic_gen
    import ddr2_tg_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int COL_BITS   = 10,
    parameter int BURST_LEN  = 32,
    parameter int WR_GAP     = 2000,
    parameter int RD_GAP     = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    ddr2_tg_if.master   bus,
    output logic        wr_over,
    output logic        rd_error,
    output logic [15:0] err_cnt,
    output logic [15:0] pass_cnt
);

    localparam int MAXG = (WR_GAP > RD_GAP) ? WR_GAP : RD_GAP;
    localparam int GW   = $clog2(MAXG + 1) + 1;
    localparam int STEP = int'(tg_addr_step(BURST_LEN));

    tg_state_e             state_q;
    logic [GW-1:0]         gap_q;
    logic                  wr_trig_q;
    logic                  rd_trig_q;
    logic [7:0]            len_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  wr_over_q;
    logic                  clr;
    logic                  rd_fin;
    logic                  row_end;

    // Dropping init_end behaves exactly like reset.
    assign clr       = rst || !init_end;
    assign wr_addr_d = wr_addr_q + ADDR_WIDTH'(STEP);
    assign rd_addr_d = rd_addr_q + ADDR_WIDTH'(STEP);
    assign rd_fin    = (state_q == S_RD_BUSY) && bus.rd_done;
    assign row_end   = rd_fin && rd_addr_d[COL_BITS];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            gap_q     <= '0;
            wr_trig_q <= 1'b0;
            rd_trig_q <= 1'b0;
            len_q     <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_over_q <= 1'b0;
        end else begin
            len_q <= 8'(BURST_LEN);
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_WR_GAP;
                end
                S_WR_GAP: begin
                    if (gap_q == GW'(WR_GAP)) begin
                        gap_q     <= '0;
                        wr_trig_q <= 1'b1;
                        state_q   <= S_WR_REQ;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_WR_REQ: begin
                    if (bus.wr_ready) begin
                        wr_trig_q <= 1'b0;
                        state_q   <= S_WR_BUSY;
                    end
                end
                S_WR_BUSY: begin
                    if (bus.wr_done) begin
                        wr_addr_q <= wr_addr_d;
                        if (wr_addr_d[COL_BITS]) begin
                            wr_over_q <= 1'b1;
                            state_q   <= S_RD_GAP;
                        end else begin
                            state_q <= S_WR_GAP;
                        end
                    end
                end
                S_RD_GAP: begin
                    if (gap_q == GW'(RD_GAP)) begin
                        gap_q     <= '0;
                        rd_trig_q <= 1'b1;
                        state_q   <= S_RD_REQ;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_RD_REQ: begin
                    if (bus.rd_ready) begin
                        rd_trig_q <= 1'b0;
                        state_q   <= S_RD_BUSY;
                    end
                end
                S_RD_BUSY: begin
                    if (bus.rd_done) begin
                        rd_addr_q <= row_end ? '0 : rd_addr_d;
                        state_q   <= S_RD_GAP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Pattern source advances on every consumed beat, regardless of state.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_data_q <= DATA_WIDTH'(1);
        end else if (bus.wr_data_en) begin
            wr_data_q <= wr_data_q + DATA_WIDTH'(1);
        end
    end

    assign bus.wr_trig = wr_trig_q;
    assign bus.wr_len  = len_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.rd_trig = rd_trig_q;
    assign bus.rd_len  = len_q;
    assign bus.rd_addr = rd_addr_q;
    assign wr_over     = wr_over_q;

`ifdef DDR2_TG_CHECK_EN
    ddr2_tg_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_checker (
        .clk          (clk),
        .clr_i        (clr),
        .rd_data_i    (bus.rd_data),
        .rd_data_en_i (bus.rd_data_en),
        .rd_done_i    (rd_fin),
        .row_end_i    (row_end),
        .rd_error_o   (rd_error),
        .err_cnt_o    (err_cnt),
        .pass_cnt_o   (pass_cnt)
    );
`else
    logic unused_chk;
    assign unused_chk = ^{bus.rd_data, bus.rd_data_en, row_end};
    assign rd_error   = 1'b0;
    assign err_cnt    = '0;
    assign pass_cnt   = '0;
`endif

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen with an ideal wr/rd master and a row memory.
// Expectations for checker outputs follow whether DDR2_TG_CHECK_EN is defined.
module tb_ddr2_traffic_gen;

`ifdef DDR2_TG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        init_end;
    logic        wr_over;
    logic        rd_error;
    logic [15:0] err_cnt;
    logic [15:0] pass_cnt;

    logic [31:0] mem [0:511];
    logic [31:0] last_wr;
    int checks;
    int failures;

    ddr2_tg_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    ddr2_traffic_gen #(
        .ADDR_WIDTH (26),
        .DATA_WIDTH (32),
        .COL_BITS   (10),
        .BURST_LEN  (32),
        .WR_GAP     (4),
        .RD_GAP     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .init_end (init_end),
        .bus      (bus),
        .wr_over  (wr_over),
        .rd_error (rd_error),
        .err_cnt  (err_cnt),
        .pass_cnt (pass_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ce(input logic [31:0] v);
        return CHK ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic trig_lat(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.wr_trig !== 1'b1 && n < 50);
        check(tag, n, 6);
    endtask

    task automatic wr_burst(output logic [25:0] a);
        int n;
        int idx;
        n = 0;
        while (bus.wr_trig !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("wr_trig_timeout", 0, 1);
        a = bus.wr_addr;
        idx = int'(a[9:1]);
        bus.wr_ready = 1'b1;
        @(negedge clk);
        bus.wr_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.wr_data_en = 1'b1;
            bus.wr_done = (i == 31);
            mem[(idx + i) % 512] = bus.wr_data;
            last_wr = bus.wr_data;
            @(negedge clk);
        end
        bus.wr_data_en = 1'b0;
        bus.wr_done = 1'b0;
    endtask

    task automatic rd_burst(input bit drop, input int corrupt,
                            output logic [25:0] a);
        int n;
        int idx;
        int nb;
        n = 0;
        while (bus.rd_trig !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rd_trig_timeout", 0, 1);
        a = bus.rd_addr;
        idx = int'(a[9:1]);
        nb = drop ? 31 : 32;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        bus.rd_ready = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.rd_data_en = 1'b1;
            bus.rd_data = mem[(idx + i) % 512] ^ ((i == corrupt) ? 32'd1 : 32'd0);
            bus.rd_done = (i == nb - 1);
            @(negedge clk);
        end
        bus.rd_data_en = 1'b0;
        bus.rd_done = 1'b0;
    endtask

    task automatic rd_pass(input int drop_b, input int cor_b, input int cor_i);
        logic [25:0] a;
        int bad;
        bad = 0;
        for (int b = 0; b < 16; b++) begin
            rd_burst(b == drop_b, (b == cor_b) ? cor_i : -1, a);
            if (a != 26'(b * 64)) bad++;
            if (b == cor_b) begin
                check("corrupt_err_cnt", {16'd0, err_cnt}, ce(1));
                check("corrupt_rd_error", {31'd0, rd_error}, ce(1));
            end
        end
        check("rd_addr_seq_bad", bad, 0);
        check("rd_addr_wrap", {6'd0, bus.rd_addr}, 0);
    endtask

    initial begin
        logic [25:0] a;
        checks = 0;
        failures = 0;
        last_wr = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        rst = 1'b1;
        init_end = 1'b1;
        bus.wr_data_en = 0;
        bus.wr_ready = 0;
        bus.wr_done = 0;
        bus.rd_data = '0;
        bus.rd_data_en = 0;
        bus.rd_ready = 0;
        bus.rd_done = 0;
        repeat (3) @(negedge clk);

        check("rst_wr_trig", {31'd0, bus.wr_trig}, 0);
        check("rst_rd_trig", {31'd0, bus.rd_trig}, 0);
        check("rst_wr_data", bus.wr_data, 1);
        check("rst_wr_addr", {6'd0, bus.wr_addr}, 0);
        check("rst_wr_over", {31'd0, wr_over}, 0);
        check("rst_err_cnt", {16'd0, err_cnt}, 0);

        rst = 1'b0;
        trig_lat("first_trig_latency");
        check("first_wr_addr", {6'd0, bus.wr_addr}, 0);
        check("first_wr_data", bus.wr_data, 1);
        check("wr_len", {24'd0, bus.wr_len}, 32);
        @(negedge clk);

        begin
            int bad;
            bad = 0;
            for (int b = 0; b < 16; b++) begin
                wr_burst(a);
                if (a != 26'(b * 64)) bad++;
                if (b == 14) check("wr_over_early", {31'd0, wr_over}, 0);
            end
            check("wr_addr_seq_bad", bad, 0);
        end
        check("wr_over_set", {31'd0, wr_over}, 1);
        check("last_wr_data", last_wr, 512);
        check("wr_data_after", bus.wr_data, 513);

        rd_pass(-1, -1, -1);
        check("p1_rd_error", {31'd0, rd_error}, 0);
        check("p1_err_cnt", {16'd0, err_cnt}, 0);
        check("p1_pass_cnt", {16'd0, pass_cnt}, ce(1));

        rd_pass(-1, 2, 5);
        check("p2_err_cnt", {16'd0, err_cnt}, ce(1));
        check("p2_pass_cnt", {16'd0, pass_cnt}, ce(2));

        rd_pass(-1, -1, -1);
        check("p3_rd_error", {31'd0, rd_error}, ce(1));
        check("p3_err_cnt", {16'd0, err_cnt}, ce(1));
        check("p3_pass_cnt", {16'd0, pass_cnt}, ce(3));

        rd_pass(14, -1, -1);
        check("p4_err_cnt", {16'd0, err_cnt}, ce(34));
        check("p4_pass_cnt", {16'd0, pass_cnt}, ce(4));
        check("p4_wr_over", {31'd0, wr_over}, 1);

        init_end = 1'b0;
        @(negedge clk);
        init_end = 1'b1;
        begin
            int n;
            n = 0;
            while (bus.wr_trig !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("re_trig_timeout", 0, 1);
        end
        bus.wr_ready = 1'b1;
        @(negedge clk);
        bus.wr_ready = 1'b0;
        bus.wr_data_en = 1'b1;
        repeat (3) @(negedge clk);
        bus.wr_data_en = 1'b0;
        check("busy_wr_data", bus.wr_data, 4);
        check("busy_wr_trig", {31'd0, bus.wr_trig}, 0);
        init_end = 1'b0;
        @(negedge clk);
        check("drop_wr_data", bus.wr_data, 1);
        check("drop_wr_addr", {6'd0, bus.wr_addr}, 0);
        check("drop_rd_addr", {6'd0, bus.rd_addr}, 0);
        check("drop_wr_over", {31'd0, wr_over}, 0);
        check("drop_rd_error", {31'd0, rd_error}, 0);
        check("drop_err_cnt", {16'd0, err_cnt}, 0);
        check("drop_pass_cnt", {16'd0, pass_cnt}, 0);
        init_end = 1'b1;
        trig_lat("restart_trig_latency");
        check("restart_wr_addr", {6'd0, bus.wr_addr}, 0);
        @(negedge clk);
        wr_burst(a);
        check("restart_burst_addr", {6'd0, a}, 0);
        check("restart_last_wr", last_wr, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
